// File: rtl/sensors_pkg.sv
// Shared types and constants for the sensor acquisition front end.
package sensors_pkg;

  // Poller sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap,
    StDone
  } state_e;

  localparam int unsigned NUM_SENSORS = 4;
  localparam int unsigned SENSOR_W    = 8;

  // A reading of 0 means "no reading" to the height-averaging stage.
  localparam logic [SENSOR_W-1:0] INVALID_READING = '0;

endpackage

// File: rtl/req_timer.sv
// Per-sensor request timer: clear/enable counter with a terminal-count flag
// raised on the last cycle a request may stay outstanding.
module req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sensors_poller.sv
// Polls four distance sensors over a shared req/ack byte bus and publishes
// all readings as one atomic frame with a single-cycle frame_valid pulse.
module sensors_poller
  import sensors_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DATA_W         = SENSOR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [1:0]        sensor_sel,
  output logic              sensor_req,
  input  logic              sensor_ack,
  input  logic [DATA_W-1:0] sensor_data,
  output logic [DATA_W-1:0] sensor1,
  output logic [DATA_W-1:0] sensor2,
  output logic [DATA_W-1:0] sensor3,
  output logic [DATA_W-1:0] sensor4,
  output logic [3:0]        err_mask,
  output logic              frame_valid,
  output logic              busy
);

  localparam logic [1:0] LastSel = 2'(NUM_SENSORS - 1);

  state_e            state_q;
  logic [1:0]        sel_q;
  logic              req_q;
  logic              busy_q;
  logic              fv_q;
  logic [3:0]        err_mask_q;
  // Only the first three readings need shadowing; the last goes straight out.
  logic [DATA_W-1:0] shadow_q [NUM_SENSORS-1];
  logic [NUM_SENSORS-2:0] err_q;
  logic [DATA_W-1:0] frame_q  [NUM_SENSORS];

  logic              tc;
  logic              timer_clr;
  logic              timer_en;
  logic              resp;
  logic [DATA_W-1:0] reading;

  // Timer runs only while a request is outstanding and is cleared otherwise.
  always_comb begin
    timer_clr = (state_q != StReq);
    timer_en  = (state_q == StReq) && !sensor_ack && !tc;
    resp      = sensor_ack || tc;
    reading   = sensor_ack ? sensor_data : DATA_W'(INVALID_READING);
  end

  req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_req_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (tc)
  );

  // Polling FSM with registered bus and frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      err_q      <= '0;
      err_mask_q <= '0;
      for (int i = 0; i < NUM_SENSORS - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) frame_q[i] <= '0;
    end else begin
      fv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          // An ack on the terminal-count cycle wins over the timeout.
          if (resp) begin
            req_q <= 1'b0;
            if (sel_q == LastSel) begin
              // Whole frame updates on one edge so consumers never see a mix.
              for (int i = 0; i < NUM_SENSORS - 1; i++) frame_q[i] <= shadow_q[i];
              frame_q[NUM_SENSORS-1] <= reading;
              err_mask_q             <= {~sensor_ack, err_q};
              fv_q                   <= 1'b1;
              state_q                <= StDone;
            end else begin
              shadow_q[sel_q] <= reading;
              err_q[sel_q]    <= ~sensor_ack;
              sel_q           <= sel_q + 2'd1;
              state_q         <= StGap;
            end
          end
        end
        StGap: begin
          // One idle cycle so every request is a fresh rising edge.
          req_q   <= 1'b1;
          state_q <= StReq;
        end
        StDone: begin
          busy_q  <= 1'b0;
          sel_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sensor_sel  = sel_q;
  assign sensor_req  = req_q;
  assign busy        = busy_q;
  assign frame_valid = fv_q;
  assign err_mask    = err_mask_q;
  assign sensor1     = frame_q[0];
  assign sensor2     = frame_q[1];
  assign sensor3     = frame_q[2];
  assign sensor4     = frame_q[3];

endmodule

// File: tb/tb_sensors_poller.sv
// Bench for sensors_poller: vector table, random frames against a reference
// model, and hand-written reset / start-while-busy sequences.
module tb_sensors_poller;

  localparam int unsigned T = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sensor_ack = 1'b0;
  logic [7:0] sensor_data = 8'd0;
  logic [1:0] sensor_sel;
  logic       sensor_req;
  logic [7:0] sensor1, sensor2, sensor3, sensor4;
  logic [3:0] err_mask;
  logic       frame_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;

  sensors_poller #(
    .TIMEOUT_CYCLES (T),
    .DATA_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sensor_sel  (sensor_sel),
    .sensor_req  (sensor_req),
    .sensor_ack  (sensor_ack),
    .sensor_data (sensor_data),
    .sensor1     (sensor1),
    .sensor2     (sensor2),
    .sensor3     (sensor3),
    .sensor4     (sensor4),
    .err_mask    (err_mask),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] dly;  // REQ cycle index of the ack; >= T means never
    logic [3:0][7:0] dat;
    logic [3:0][7:0] exp;
    logic [3:0]      err;
    logic [7:0]      cyc;  // cycle (start edge = 0) with frame_valid high
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][7:0] p4(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference: a sensor answers iff its ack comes within T request cycles;
  // each sensor costs (ack index + 1) or T cycles, plus 3 gaps and the start edge.
  task automatic model(input logic [3:0][7:0] dly, input logic [3:0][7:0] dat,
                       output logic [3:0][7:0] exp, output logic [3:0] err, output int cyc);
    cyc = 1 + 3;
    for (int i = 0; i < 4; i++) begin
      if (int'(dly[i]) < T) begin
        exp[i] = dat[i];
        err[i] = 1'b0;
        cyc += int'(dly[i]) + 1;
      end else begin
        exp[i] = 8'd0;
        err[i] = 1'b1;
        cyc += T;
      end
    end
  endtask

  // Start a frame, act as the four sensors, then check frame contents and timing.
  task automatic run_frame(input logic [3:0][7:0] dly, input logic [3:0][7:0] dat,
                           input logic [3:0][7:0] exp, input logic [3:0] err,
                           input int cyc, input bit spam, input string tag);
    int  reqcnt[4];
    int  cycle;
    int  rises;
    int  s;
    bit  seen;
    bit  prev_req;
    for (int i = 0; i < 4; i++) reqcnt[i] = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!spam) start = 1'b0;
    cycle    = 1;
    seen     = 1'b0;
    rises    = 0;
    prev_req = 1'b0;
    while (cycle < 200 && !seen) begin
      if (frame_valid) begin
        seen = 1'b1;
      end else begin
        if (sensor_req && !prev_req) rises++;
        prev_req = sensor_req;
        if (sensor_req) begin
          s = int'(sensor_sel);
          reqcnt[s]++;
          sensor_ack  = (reqcnt[s] - 1 == int'(dly[s]));
          sensor_data = sensor_ack ? dat[s] : 8'($urandom);
        end else begin
          // Noise outside REQ must be ignored.
          sensor_ack  = 1'($urandom_range(0, 1));
          sensor_data = 8'($urandom);
        end
        @(posedge clk);
        #1;
        cycle++;
      end
    end
    check({tag, " frame_valid cycle"}, cycle, cyc);
    if (seen) begin
      check({tag, " sensor1"}, sensor1, exp[0]);
      check({tag, " sensor2"}, sensor2, exp[1]);
      check({tag, " sensor3"}, sensor3, exp[2]);
      check({tag, " sensor4"}, sensor4, exp[3]);
      check({tag, " err_mask"}, err_mask, err);
      check({tag, " busy in done"}, busy, 1);
      check({tag, " req edges"}, rises, 4);
      for (int i = 0; i < 4; i++)
        check({tag, " req cycles"}, reqcnt[i], (int'(dly[i]) < T) ? int'(dly[i]) + 1 : T);
    end
    sensor_ack = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " frame_valid one cycle"}, frame_valid, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle req"}, sensor_req, 0);
  endtask

  initial begin
    logic [3:0][7:0] rd, rv, re;
    logic [3:0]      rerr;
    int              rcyc;
    int              fv_seen;
    bit              reached;

    vecs[0] = '{dly: p4(8'd0, 8'd0, 8'd0, 8'd0), dat: p4(8'd10, 8'd20, 8'd30, 8'd40),
                exp: p4(8'd10, 8'd20, 8'd30, 8'd40), err: 4'b0000, cyc: 8'd8};
    vecs[1] = '{dly: p4(8'd0, 8'd0, 8'd99, 8'd0), dat: p4(8'd10, 8'd20, 8'd30, 8'd40),
                exp: p4(8'd10, 8'd20, 8'd0, 8'd40), err: 4'b0100, cyc: 8'd12};
    vecs[2] = '{dly: p4(8'd4, 8'd0, 8'd0, 8'd0), dat: p4(8'd77, 8'd1, 8'd2, 8'd3),
                exp: p4(8'd77, 8'd1, 8'd2, 8'd3), err: 4'b0000, cyc: 8'd12};
    vecs[3] = '{dly: p4(8'd99, 8'd99, 8'd99, 8'd99), dat: p4(8'd5, 8'd6, 8'd7, 8'd8),
                exp: p4(8'd0, 8'd0, 8'd0, 8'd0), err: 4'b1111, cyc: 8'd24};
    vecs[4] = '{dly: p4(8'd1, 8'd2, 8'd3, 8'd0), dat: p4(8'd0, 8'd5, 8'd0, 8'd255),
                exp: p4(8'd0, 8'd5, 8'd0, 8'd255), err: 4'b0000, cyc: 8'd14};

    // Reset state.
    #12;
    check("rst sel", sensor_sel, 0);
    check("rst req", sensor_req, 0);
    check("rst sensor1", sensor1, 0);
    check("rst sensor4", sensor4, 0);
    check("rst err_mask", err_mask, 0);
    check("rst frame_valid", frame_valid, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst busy", busy, 0);

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].dly, vecs[v].dat, vecs[v].exp, vecs[v].err, int'(vecs[v].cyc),
                1'b0, $sformatf("vec%0d", v));

    // start held high throughout the frame, including the DONE cycle.
    run_frame(vecs[0].dly, vecs[0].dat, vecs[0].exp, vecs[0].err, int'(vecs[0].cyc),
              1'b1, "spam");
    fv_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid || busy) fv_seen++;
    end
    check("spam single frame", fv_seen, 0);

    // Random frames against the reference model.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        rd[i] = 8'($urandom_range(0, 7));
        rv[i] = 8'($urandom);
      end
      model(rd, rv, re, rerr, rcyc);
      run_frame(rd, rv, re, rerr, rcyc, 1'b0, $sformatf("rnd%0d", n));
    end

    // Reset during REQ for sensor index 2, with a nonzero previous frame.
    run_frame(vecs[0].dly, vecs[0].dat, vecs[0].exp, vecs[0].err, int'(vecs[0].cyc),
              1'b0, "pre-rst");
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      if (sensor_req && sensor_sel == 2'd2) begin
        reached = 1'b1;
      end else begin
        sensor_ack  = sensor_req;
        sensor_data = 8'd9;
        @(posedge clk);
        #1;
      end
    end
    check("reach sel2", reached, 1);
    sensor_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst req", sensor_req, 0);
    check("midrst sel", sensor_sel, 0);
    check("midrst busy", busy, 0);
    check("midrst frame_valid", frame_valid, 0);
    check("midrst sensor1", sensor1, 0);
    check("midrst sensor2", sensor2, 0);
    check("midrst sensor3", sensor3, 0);
    check("midrst sensor4", sensor4, 0);
    check("midrst err_mask", err_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid || busy) fv_seen++;
    end
    check("midrst no frame", fv_seen, 0);
    run_frame(vecs[0].dly, vecs[0].dat, vecs[0].exp, vecs[0].err, int'(vecs[0].cyc),
              1'b0, "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensors_poller.md
Name: sensors_poller

Overview:
- Acquisition front end that feeds the height-averaging stage.
- On a start pulse, polls the four distance sensors one at a time over a shared request/acknowledge byte bus.
- Stores one reading per sensor and presents all four readings together as one frame, plus a one-cycle frame_valid pulse.
- A sensor that does not answer is reported as 0. The averaging stage treats 0 as "no reading", so its existing 2-of-4 fallback applies.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles sensor_req stays high for one sensor before that sensor is declared absent; legal range 2..65535.
- DATA_W, 8, sensor reading width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new frame; sampled only in IDLE.
- sensor_sel  out  2  index of the sensor being polled (0..3).
- sensor_req  out  1  read request to the selected sensor.
- sensor_ack  in  1  selected sensor's data is valid this cycle.
- sensor_data  in  DATA_W  reading from the selected sensor.
- sensor1..sensor4  out  DATA_W each  frame readings, feeding the height-averaging stage.
- err_mask  out  4  bit i set: sensor i+1 timed out in the last frame.
- frame_valid  out  1  one-cycle pulse; the frame outputs are new.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately; sensor_req drops immediately.
  - All outputs are 0 (sel, req, sensor1..4, err_mask, frame_valid, busy).
  - Shadow registers and the timer are 0.
  - Reset mid-frame discards the partial frame; no frame_valid.
- States: IDLE, REQ, GAP, DONE.
- IDLE:
  - start=1 at an edge: sel<=0, timer<=0, go to REQ.
  - start while busy is ignored; no queuing.
- REQ:
  - sensor_req=1, sensor_sel=current index.
  - If sensor_ack=1 at an edge: shadow[sel]<=sensor_data, err bit <=0.
  - Else if timer==TIMEOUT_CYCLES-1: shadow[sel]<=0, err bit <=1.
  - Else timer++.
  - On ack or timeout: if sel<3, go to GAP and sel++; if sel==3, go to DONE.
  - sensor_req is therefore high for at most TIMEOUT_CYCLES consecutive cycles per sensor.
  - An ack on the final timer cycle wins over the timeout.
- GAP:
  - One cycle with sensor_req=0, so every request is a distinct rising edge.
  - timer<=0, go to REQ.
- DONE transition:
  - On the edge that leaves REQ for sensor 3 (the 4th sensor, sel==3), sensor1..4 and err_mask load from the shadow registers and the final reading, all in the same edge.
  - The frame outputs therefore never show a mix of two frames.
  - frame_valid=1 for exactly the DONE cycle, then go to IDLE.
  - start in the DONE cycle is ignored.
- Ack and data outside REQ are ignored.
- sensor_data=0 with ack is stored as 0 with no error flag.
- Latency, immediate acks (ack high in every REQ cycle):
  - start sampled at edge 0; REQ occupies cycles 1, 3, 5, 7; GAP occupies cycles 2, 4, 6.
  - frame_valid is high in cycle 8; next start can be accepted at edge 9.
- Worst case, all sensors time out: 4*TIMEOUT_CYCLES + 3 GAP cycles + 1 DONE cycle after the start edge.
- Frame outputs hold their value between frames.

Decomposition:
- Shared package sensors_pkg:
  - State enum {IDLE, REQ, GAP, DONE}.
  - NUM_SENSORS=4.
  - SENSOR_W=8.
  - Invalid-reading constant 0, shared with the averaging stage.
- One natural sub-module: req_timer.
  - Clear/enable counter whose width is derived from TIMEOUT_CYCLES.
  - Produces a terminal-count flag.

Test Plan:
- Reset → all outputs 0 (sel, req, sensor1..4, err_mask, frame_valid, busy); busy=0.
- Immediate acks with data 10, 20, 30, 40:
  - frame_valid is high in cycle 8 only.
  - sensor1..4 read 10/20/30/40; err_mask=0000.
  - sensor_req toggles 1,0,1,0,1,0,1.
- Sensor 3 never acks, TIMEOUT_CYCLES=5:
  - sensor_req stays high for exactly 5 cycles at sel=2.
  - Result: sensor3=0, err_mask=0100; other readings correct.
- Ack arrives on the final timeout cycle with data 77 → stored 77, error bit clear.
- start pulsed mid-frame and again in the DONE cycle → exactly one frame produced.
- rst_n asserted while sel=2 during REQ → sensor_req=0 immediately; no frame_valid; previous frame outputs cleared to 0.
